// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables and flushes,
// I/D-cache fill-port arbitration, HLT drain, and a stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             hlt_id,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             mem_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DC_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_IFILL  = 3'd1,
        S_DFILL  = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            r_ret;
    state_t            w_ret_nxt;
    logic [DC_W-1:0]   r_drain_cnt;
    logic [DC_W-1:0]   w_drain_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    // State, return state, drain countdown and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_ret       <= S_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (!pc_en && (r_state != S_HALTED) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state decode; a D-cache miss always takes the fill port first
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (dcache_miss) begin
                    w_ret_nxt   = S_RUN;
                    w_state_nxt = S_DFILL;
                end else if (!stall_req && !branch_taken) begin
                    if (hlt_id) begin
                        w_drain_nxt = DC_W'(DRAIN_CYCLES - 1);
                        w_state_nxt = S_DRAIN;
                    end else if (icache_miss) begin
                        w_state_nxt = S_IFILL;
                    end
                end
            end
            S_IFILL: begin
                if (mem_done) begin
                    if (dcache_miss) begin
                        w_ret_nxt   = S_RUN;
                        w_state_nxt = S_DFILL;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_DFILL: begin
                if (mem_done) begin
                    w_state_nxt = r_ret;
                end
            end
            S_DRAIN: begin
                if (dcache_miss) begin
                    w_ret_nxt   = S_DRAIN;
                    w_state_nxt = S_DFILL;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt - DC_W'(1);
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Output decode from state and inputs; everything held low during reset
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        halted      = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_RUN: begin
                    if (dcache_miss) begin
                        // whole pipe frozen while MEM waits for data
                    end else if (stall_req) begin
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (branch_taken) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (hlt_id || icache_miss) begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                    end
                end
                S_IFILL: begin
                    mem_req = 1'b1;
                    if (!dcache_miss) begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
                S_DFILL: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                end
                S_DRAIN: begin
                    // a D miss during drain freezes the pipe like in RUN
                    if (!dcache_miss) begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stalls, branch redirect, I/D fills, HLT drain, reset.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_req;
    logic        branch_taken;
    logic        hlt_id;
    logic        icache_miss;
    logic        dcache_miss;
    logic        mem_done;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_req;
    logic        mem_sel;
    logic        halted;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl #(
        .DRAIN_CYCLES(4),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_req   (stall_req),
        .branch_taken(branch_taken),
        .hlt_id      (hlt_id),
        .icache_miss (icache_miss),
        .dcache_miss (dcache_miss),
        .mem_done    (mem_done),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [4:0] w_en;
    // {if_id_flush, id_ex_flush}
    logic [1:0] w_fl;
    // {mem_req, mem_sel}
    logic [1:0] w_mem;
    assign w_en  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign w_fl  = {if_id_flush, id_ex_flush};
    assign w_mem = {mem_req, mem_sel};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        stall_req    = 1'b0;
        branch_taken = 1'b0;
        hlt_id       = 1'b0;
        icache_miss  = 1'b0;
        dcache_miss  = 1'b0;
        mem_done     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #2;
        chk("rst_en",    32'(w_en),     32'h00);
        chk("rst_fl",    32'(w_fl),     32'h0);
        chk("rst_mem",   32'(w_mem),    32'h0);
        chk("rst_halt",  32'(halted),   32'h0);
        chk("rst_cnt",   32'(stall_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("run_en", 32'(w_en), 32'h1F);
        chk("run_fl", 32'(w_fl), 32'h0);

        // load-use stall for one cycle
        tick();
        stall_req = 1'b1;
        @(negedge clk);
        chk("stall_en", 32'(w_en), 32'h07);
        chk("stall_fl", 32'(w_fl), 32'h1);
        tick();
        clr();
        @(negedge clk);
        chk("stall_cnt", 32'(stall_cnt), 32'd1);
        chk("stall_after_en", 32'(w_en), 32'h1F);

        // taken branch masks a wrong-path I-cache miss
        tick();
        branch_taken = 1'b1;
        icache_miss  = 1'b1;
        @(negedge clk);
        chk("br_en",  32'(w_en),  32'h1F);
        chk("br_fl",  32'(w_fl),  32'h2);
        chk("br_mem", 32'(w_mem), 32'h0);
        tick();
        clr();
        @(negedge clk);
        chk("br_stay_run", 32'(w_mem), 32'h0);
        chk("br_en2",      32'(w_en),  32'h1F);
        chk("br_cnt",      32'(stall_cnt), 32'd1);

        // I-cache miss with a 3-cycle fill
        tick();
        icache_miss = 1'b1;
        @(negedge clk);
        chk("imiss_en",  32'(w_en),  32'h0F);
        chk("imiss_fl",  32'(w_fl),  32'h2);
        chk("imiss_mem", 32'(w_mem), 32'h0);
        tick();
        icache_miss = 1'b0;
        @(negedge clk);
        chk("ifill1_mem", 32'(w_mem), 32'h2);
        chk("ifill1_en",  32'(w_en),  32'h0F);
        chk("ifill1_fl",  32'(w_fl),  32'h2);
        tick();
        @(negedge clk);
        chk("ifill2_mem", 32'(w_mem), 32'h2);
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        chk("ifill3_mem", 32'(w_mem), 32'h2);
        tick();
        clr();
        @(negedge clk);
        chk("ifill_ret_mem", 32'(w_mem), 32'h0);
        chk("ifill_ret_en",  32'(w_en),  32'h1F);
        chk("ifill_cnt",     32'(stall_cnt), 32'd5);

        // D miss arrives during an I fill and takes the port next
        tick();
        icache_miss = 1'b1;
        tick();
        icache_miss = 1'b0;
        tick();
        dcache_miss = 1'b1;
        @(negedge clk);
        chk("id_c2_en",  32'(w_en),  32'h00);
        chk("id_c2_fl",  32'(w_fl),  32'h0);
        chk("id_c2_mem", 32'(w_mem), 32'h2);
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        chk("id_c3_en", 32'(w_en), 32'h00);
        tick();
        mem_done = 1'b0;
        @(negedge clk);
        chk("dfill1_mem", 32'(w_mem), 32'h3);
        chk("dfill1_en",  32'(w_en),  32'h00);
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        chk("dfill2_mem", 32'(w_mem), 32'h3);
        tick();
        clr();
        @(negedge clk);
        chk("id_ret_en",  32'(w_en),  32'h1F);
        chk("id_ret_mem", 32'(w_mem), 32'h0);
        chk("id_cnt",     32'(stall_cnt), 32'd11);

        // D miss from RUN with a single-cycle fill; stray mem_done in RUN ignored
        tick();
        dcache_miss = 1'b1;
        @(negedge clk);
        chk("dmiss_en",  32'(w_en),  32'h00);
        chk("dmiss_mem", 32'(w_mem), 32'h0);
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        chk("dmin_mem", 32'(w_mem), 32'h3);
        tick();
        clr();
        @(negedge clk);
        chk("dmin_ret_mem", 32'(w_mem), 32'h0);
        chk("dmin_cnt",     32'(stall_cnt), 32'd13);
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        chk("stray_done_en",  32'(w_en),  32'h1F);
        chk("stray_done_mem", 32'(w_mem), 32'h0);
        tick();
        clr();

        // HLT: four drain cycles, then halted
        hlt_id = 1'b1;
        @(negedge clk);
        chk("hlt_en", 32'(w_en), 32'h0F);
        chk("hlt_fl", 32'(w_fl), 32'h2);
        tick();
        hlt_id = 1'b0;
        @(negedge clk);
        chk("drain1_en",   32'(w_en),  32'h0F);
        chk("drain1_halt", 32'(halted), 32'h0);
        tick();
        stall_req    = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        chk("drain2_ign_en", 32'(w_en), 32'h0F);
        chk("drain2_ign_fl", 32'(w_fl), 32'h2);
        tick();
        clr();
        tick();
        @(negedge clk);
        chk("drain4_halt", 32'(halted), 32'h0);
        tick();
        @(negedge clk);
        chk("halted",      32'(halted), 32'h1);
        chk("halted_en",   32'(w_en),   32'h00);
        chk("halted_fl",   32'(w_fl),   32'h0);
        chk("halted_cnt",  32'(stall_cnt), 32'd18);
        tick();
        stall_req   = 1'b1;
        dcache_miss = 1'b1;
        @(negedge clk);
        chk("halted_hold",     32'(halted), 32'h1);
        chk("halted_hold_mem", 32'(w_mem),  32'h0);
        tick();
        clr();
        @(negedge clk);
        chk("halted_cnt_hold", 32'(stall_cnt), 32'd18);

        // reset out of HALTED
        rst_n = 1'b0;
        #1;
        chk("rst2_halt", 32'(halted),    32'h0);
        chk("rst2_cnt",  32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_en", 32'(w_en), 32'h1F);

        // HLT with a 2-cycle D fill in drain cycle 2: halt 3 cycles later
        tick();
        hlt_id = 1'b1;
        tick();
        hlt_id = 1'b0;
        tick();
        dcache_miss = 1'b1;
        @(negedge clk);
        chk("dd_detect_pc",  32'(pc_en),  32'h0);
        chk("dd_detect_mem", 32'(w_mem),  32'h0);
        tick();
        @(negedge clk);
        chk("dd_fill1_mem", 32'(w_mem), 32'h3);
        tick();
        mem_done = 1'b1;
        tick();
        clr();
        @(negedge clk);
        chk("dd_back_en",  32'(w_en),  32'h0F);
        chk("dd_back_mem", 32'(w_mem), 32'h0);
        tick();
        tick();
        @(negedge clk);
        chk("dd_last_halt", 32'(halted), 32'h0);
        tick();
        @(negedge clk);
        chk("dd_halted",     32'(halted),    32'h1);
        chk("dd_halted_cnt", 32'(stall_cnt), 32'd8);

        // reset asserted mid-fill drops mem_req at once
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dcache_miss = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rf_fill2_mem", 32'(w_mem), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("rf_async_mem", 32'(w_mem), 32'h0);
        chk("rf_async_en",  32'(w_en),  32'h00);
        clr();
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rf_rel_en",  32'(w_en),     32'h1F);
        chk("rf_rel_mem", 32'(w_mem),    32'h0);
        chk("rf_rel_cnt", 32'(stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
